// File: rtl/traffic_ctrl_multi.sv
// N-direction traffic-light sequencer with seconds prescaler, pedestrian green
// truncation, night flashing-yellow mode and per-direction countdown outputs.
module traffic_ctrl_multi #(
   parameter int NUM_DIR      = 2,
   parameter int CLK_PER_SEC  = 1000,
   parameter int GREEN_TIME   = 25,
   parameter int YELLOW_TIME  = 3,
   parameter int ALL_RED_TIME = 2,
   parameter int MIN_GREEN    = 5,
   parameter int CNT_W        = 8
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic                     night_mode,
   input  logic [NUM_DIR-1:0]       ped_req,
   output logic [NUM_DIR-1:0]       red,
   output logic [NUM_DIR-1:0]       yellow,
   output logic [NUM_DIR-1:0]       green,
   output logic [NUM_DIR*CNT_W-1:0] count,
   output logic [1:0]               active,
   output logic                     tick
);

   localparam int PC_W  = $clog2(CLK_PER_SEC);
   localparam int SEC_W = $clog2(GREEN_TIME + YELLOW_TIME + ALL_RED_TIME + 1);
   localparam int SUM_W = CNT_W + 4;
   localparam int PHASE = GREEN_TIME + YELLOW_TIME + ALL_RED_TIME;

   // state   | meaning
   // GREEN   | active direction green, others red
   // YELLOW  | active direction yellow, others red
   // ALL_RED | clearance, every direction red
   // NIGHT   | all yellows flash on the blink bit
   localparam logic [1:0] S_GREEN   = 2'd0;
   localparam logic [1:0] S_YELLOW  = 2'd1;
   localparam logic [1:0] S_ALL_RED = 2'd2;
   localparam logic [1:0] S_NIGHT   = 2'd3;

   localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(CLK_PER_SEC - 1);
   localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
   localparam logic [SEC_W-1:0] G_S      = SEC_W'(GREEN_TIME);
   localparam logic [SEC_W-1:0] Y_S      = SEC_W'(YELLOW_TIME);
   localparam logic [SEC_W-1:0] AR_S     = SEC_W'(ALL_RED_TIME);
   localparam logic [SEC_W-1:0] MIN_S    = SEC_W'(MIN_GREEN);
   localparam logic [SUM_W-1:0] Y_W      = SUM_W'(YELLOW_TIME);
   localparam logic [SUM_W-1:0] AR_W     = SUM_W'(ALL_RED_TIME);
   localparam logic [SUM_W-1:0] PHASE_W  = SUM_W'(PHASE);
   localparam logic [SUM_W-1:0] CNT_MAX  = {4'b0, {CNT_W{1'b1}}};
   localparam logic [1:0]       LAST_DIR = 2'(NUM_DIR - 1);

   logic [1:0]         state;
   logic [SEC_W-1:0]   sec;
   logic [PC_W-1:0]    pc;
   logic [NUM_DIR-1:0] p;
   logic               blink;

   logic [1:0]         next_active;
   logic [NUM_DIR-1:0] act_oh;
   logic [NUM_DIR-1:0] nxt_oh;
   logic [NUM_DIR-1:0] p_next;
   logic               enter_green;
   logic               trunc;
   logic [SUM_W-1:0]   rem;
   logic [SUM_W-1:0]   sum;
   int                 di;

   assign tick        = (pc == PC_LAST);
   assign next_active = (active == LAST_DIR) ? 2'd0 : active + 2'd1;
   assign enter_green = (state == S_ALL_RED) && tick && (sec == SEC_ONE) && !night_mode;
   assign trunc       = (state == S_GREEN) && (|(p & ~act_oh)) && (sec > MIN_S);

   always_comb begin
      act_oh = '0;
      nxt_oh = '0;
      for (int i = 0; i < NUM_DIR; i++) begin
         act_oh[i] = (i == int'(active));
         nxt_oh[i] = (i == int'(next_active));
      end
   end

   // A request landing on the clear cycle survives: clear first, then OR in.
   assign p_next = (p & ~(enter_green ? nxt_oh : '0))
                 | (ped_req & ~((state == S_GREEN) ? act_oh : '0));

   always_ff @(posedge clock) begin
      if (rst) begin
         state  <= S_ALL_RED;
         sec    <= AR_S;
         active <= LAST_DIR;
         pc     <= '0;
         p      <= '0;
         blink  <= 1'b0;
      end else begin
         pc <= tick ? '0 : pc + PC_W'(1);
         p  <= p_next;
         case (state)
            S_GREEN: begin
               if (trunc) begin
                  sec <= MIN_S;
               end else if (tick) begin
                  if (sec == SEC_ONE) begin
                     state <= S_YELLOW;
                     sec   <= Y_S;
                  end else begin
                     sec <= sec - SEC_ONE;
                  end
               end
            end
            S_YELLOW: begin
               if (tick) begin
                  if (sec == SEC_ONE) begin
                     state <= S_ALL_RED;
                     sec   <= AR_S;
                  end else begin
                     sec <= sec - SEC_ONE;
                  end
               end
            end
            S_ALL_RED: begin
               if (tick) begin
                  if (sec == SEC_ONE) begin
                     if (night_mode) begin
                        state <= S_NIGHT;
                        blink <= 1'b1;
                     end else begin
                        state  <= S_GREEN;
                        active <= next_active;
                        sec    <= G_S;
                     end
                  end else begin
                     sec <= sec - SEC_ONE;
                  end
               end
            end
            default: begin
               if (tick) begin
                  if (!night_mode) begin
                     state  <= S_ALL_RED;
                     sec    <= AR_S;
                     active <= LAST_DIR;
                  end else begin
                     blink <= ~blink;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      red    = '0;
      yellow = '0;
      green  = '0;
      case (state)
         S_GREEN: begin
            green = act_oh;
            red   = ~act_oh;
         end
         S_YELLOW: begin
            yellow = act_oh;
            red    = ~act_oh;
         end
         S_ALL_RED: red    = '1;
         default:   yellow = {NUM_DIR{blink}};
      endcase
   end

   // rem is seconds to the end of the next ALL_RED; each further direction
   // in the rotation waits one more full phase.
   always_comb begin
      count = '0;
      sum   = '0;
      di    = 0;
      rem   = SUM_W'(sec);
      if (state == S_GREEN)
         rem = SUM_W'(sec) + Y_W + AR_W;
      else if (state == S_YELLOW)
         rem = SUM_W'(sec) + AR_W;
      if (state != S_NIGHT) begin
         for (int i = 0; i < NUM_DIR; i++) begin
            if ((state != S_ALL_RED) && (i == int'(active))) begin
               sum = SUM_W'(sec);
            end else begin
               di = i - int'(active);
               if (di <= 0)
                  di = di + NUM_DIR;
               sum = rem + SUM_W'(di - 1) * PHASE_W;
            end
            count[i*CNT_W +: CNT_W] = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi: a schedule-level model checked every
// cycle, plus literal expectations at hand-computed cycle numbers.
module tb_traffic_ctrl_multi;
   localparam int N     = 3;
   localparam int CPS   = 4;
   localparam int GT    = 5;
   localparam int YT    = 2;
   localparam int ART   = 1;
   localparam int MG    = 2;
   localparam int CW    = 8;
   localparam int PHASE = GT + YT + ART;

   localparam int PH_G = 0;
   localparam int PH_Y = 1;
   localparam int PH_R = 2;
   localparam int PH_N = 3;

   logic          clock = 1'b0;
   logic          rst = 1'b1;
   logic          night_mode = 1'b0;
   logic [N-1:0]  ped_req = '0;
   logic [N-1:0]  red, yellow, green;
   logic [N*CW-1:0] count;
   logic [1:0]    active;
   logic          tick;

   traffic_ctrl_multi #(
      .NUM_DIR(N), .CLK_PER_SEC(CPS), .GREEN_TIME(GT), .YELLOW_TIME(YT),
      .ALL_RED_TIME(ART), .MIN_GREEN(MG), .CNT_W(CW)
   ) dut (
      .clock(clock), .rst(rst), .night_mode(night_mode), .ped_req(ped_req),
      .red(red), .yellow(yellow), .green(green), .count(count),
      .active(active), .tick(tick)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   // model: cycles since reset, phase kind, seconds left, owning direction
   int  m_cyc = 0;
   int  m_ph = PH_R;
   int  m_left = ART;
   int  m_dir = N - 1;
   bit  m_req [N];
   bit  m_blink = 1'b0;
   bit  m_valid = 1'b0;
   bit  tk, other_req, entering;
   bit  nreq [N];

   always @(posedge clock) begin
      if (rst) begin
         m_cyc = 0; m_ph = PH_R; m_left = ART; m_dir = N - 1; m_blink = 1'b0;
         for (int j = 0; j < N; j++) m_req[j] = 1'b0;
         m_valid = 1'b1;
      end else begin
         tk = ((m_cyc % CPS) == CPS - 1);
         entering = 1'b0;
         other_req = 1'b0;
         for (int j = 0; j < N; j++) begin
            if (m_req[j] && j != m_dir) other_req = 1'b1;
            nreq[j] = m_req[j] | (ped_req[j] && !(m_ph == PH_G && j == m_dir));
         end
         if (m_ph == PH_G && other_req && m_left > MG) begin
            m_left = MG;
         end else if (tk) begin
            if (m_ph == PH_N) begin
               if (!night_mode) begin
                  m_ph = PH_R; m_left = ART; m_dir = N - 1;
               end else begin
                  m_blink = !m_blink;
               end
            end else if (m_left > 1) begin
               m_left = m_left - 1;
            end else if (m_ph == PH_G) begin
               m_ph = PH_Y; m_left = YT;
            end else if (m_ph == PH_Y) begin
               m_ph = PH_R; m_left = ART;
            end else if (night_mode) begin
               m_ph = PH_N; m_blink = 1'b1;
            end else begin
               m_ph = PH_G; m_left = GT; m_dir = (m_dir + 1) % N; entering = 1'b1;
            end
         end
         if (entering) nreq[m_dir] = ped_req[m_dir];
         for (int j = 0; j < N; j++) m_req[j] = nreq[j];
         m_cyc = m_cyc + 1;
      end
   end

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   // Walk the rotation from the next owner up to direction i, a phase per hop.
   function automatic int exp_cnt(input int i);
      int t, k;
      if (m_ph == PH_N) return 0;
      if (i == m_dir && m_ph != PH_R) return sat(m_left);
      t = m_left + ((m_ph == PH_G) ? YT + ART : (m_ph == PH_Y) ? ART : 0);
      k = (m_dir + 1) % N;
      while (k != i) begin
         t = t + PHASE;
         k = (k + 1) % N;
      end
      return sat(t);
   endfunction

   logic [N-1:0]    er, ey, eg;
   logic [N*CW-1:0] ec;
   logic [1:0]      ea;
   logic            et;

   always @(negedge clock) begin
      if (m_valid) begin
         er = '0; ey = '0; eg = '0; ec = '0;
         for (int i = 0; i < N; i++) begin
            case (m_ph)
               PH_G: begin eg[i] = (i == m_dir); er[i] = (i != m_dir); end
               PH_Y: begin ey[i] = (i == m_dir); er[i] = (i != m_dir); end
               PH_R: er[i] = 1'b1;
               default: ey[i] = m_blink;
            endcase
            ec[i*CW +: CW] = CW'(exp_cnt(i));
         end
         ea = 2'(m_dir);
         et = ((m_cyc % CPS) == CPS - 1);
         checks++;
         if ({red, yellow, green, count, tick} !== {er, ey, eg, ec, et} ||
             (m_ph != PH_N && active !== ea)) begin
            failures++;
            $display("FAIL cycle_model t=%0t red=%b want %b yellow=%b want %b green=%b want %b count=%h want %h active=%0d want %0d tick=%b want %b",
                     $time, red, er, yellow, ey, green, eg, count, ec, active, ea, tick, et);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
      end
   endtask

   task automatic goto(input int k);
      int guard = 0;
      while (m_cyc < k && guard < 2000) begin
         @(negedge clock);
         guard++;
      end
      checks++;
      if (guard >= 2000) begin
         failures++;
         $display("FAIL goto_timeout got=%0d want=%0d", m_cyc, k);
      end
   endtask

   initial begin
      repeat (2) @(negedge clock);
      rst = 1'b0;
      chk("reset_red", int'(red), 7);
      chk("reset_green", int'(green), 0);
      chk("reset_cnt0", int'(count[0 +: CW]), 1);
      chk("reset_cnt1", int'(count[CW +: CW]), 9);
      chk("reset_cnt2", int'(count[2*CW +: CW]), 17);
      goto(3);   chk("first_tick", int'(tick), 1);
      goto(4);   chk("first_green", int'(green), 1);
                 chk("g0_cnt0", int'(count[0 +: CW]), 5);
                 chk("g0_cnt1", int'(count[CW +: CW]), 8);
                 chk("g0_cnt2", int'(count[2*CW +: CW]), 16);
      goto(23);  chk("green_last", int'(green), 1);
      goto(24);  chk("yellow0", int'(yellow), 1);
                 chk("yellow0_cnt", int'(count[0 +: CW]), 2);
      goto(36);  chk("green1", int'(green), 2);
      goto(68);  chk("green2", int'(green), 4);
      goto(100); chk("green0_again", int'(green), 1);
      goto(104); chk("sec4", int'(count[0 +: CW]), 4);
      ped_req = 3'b100;
      goto(105); ped_req = 3'b000;
      goto(106); chk("ped_trunc", int'(count[0 +: CW]), 2);
      goto(111); chk("trunc_green", int'(green), 1);
      goto(112); chk("trunc_yellow", int'(yellow), 1);
      goto(125); chk("trunc_dir1", int'(count[CW +: CW]), 2);
      goto(144); chk("green2_ped", int'(green), 4);
      goto(145); ped_req = 3'b100;
      goto(146); ped_req = 3'b000;
      goto(156); ped_req = 3'b001;
      goto(157); ped_req = 3'b000;
      goto(158); chk("no_trunc_sec2", int'(count[2*CW +: CW]), 2);
      goto(177); chk("no_trunc_dir0", int'(count[0 +: CW]), 5);
      goto(180); night_mode = 1'b1;
      goto(208); chk("night_yellow", int'(yellow), 7);
                 chk("night_red", int'(red), 0);
                 chk("night_cnt1", int'(count[CW +: CW]), 0);
      goto(212); chk("night_blink", int'(yellow), 0);
      goto(216); chk("night_blink2", int'(yellow), 7);
      goto(217); night_mode = 1'b0;
      goto(220); chk("night_exit_red", int'(red), 7);
                 chk("night_exit_act", int'(active), 2);
      goto(224); chk("night_exit_green", int'(green), 1);
      goto(244); chk("yellow_pre_rst", int'(yellow), 1);
      goto(245); ped_req = 3'b010;
      goto(246); ped_req = 3'b000; rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      chk("rst2_red", int'(red), 7);
      chk("rst2_yellow", int'(yellow), 0);
      chk("rst2_cnt2", int'(count[2*CW +: CW]), 17);
      chk("rst2_tick", int'(tick), 0);
      goto(3);   chk("rst2_tick3", int'(tick), 1);
      goto(4);   chk("rst2_green", int'(green), 1);
      goto(5);   chk("rst2_latch_clr", int'(count[0 +: CW]), 5);
      goto(8);   chk("rst2_sec4", int'(count[0 +: CW]), 4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/traffic_ctrl_multi.md
# traffic_ctrl_multi

Parametrised N-direction traffic-light controller, the successor to the fixed two-direction controller. It runs entirely on the system clock and uses an internal seconds prescaler instead of derived clocks. It sequences GREEN → YELLOW → ALL_RED round-robin over NUM_DIR directions, adds pedestrian-request green truncation and a night flashing-yellow mode, and outputs a per-direction binary countdown for the existing display blocks.

## Interface
- NUM_DIR, 2: number of directions, legal range 2..4.
- CLK_PER_SEC, 1000: clock cycles per one-second tick, ≥2.
- GREEN_TIME, 25: green duration in seconds, ≥2.
- YELLOW_TIME, 3: yellow duration in seconds, ≥1.
- ALL_RED_TIME, 2: all-red clearance in seconds, ≥1.
- MIN_GREEN, 5: green remaining after a truncating pedestrian request, 1..GREEN_TIME.
- CNT_W, 8: countdown width per direction.
- clock  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- night_mode  in  1  level request for flashing-yellow mode.
- ped_req  in  NUM_DIR  1-cycle-or-longer pulse per direction requesting its green.
- red  out  NUM_DIR  red lamp per direction.
- yellow  out  NUM_DIR  yellow lamp per direction.
- green  out  NUM_DIR  green lamp per direction.
- count  out  NUM_DIR*CNT_W  seconds remaining per direction; direction i is at bits [i*CNT_W +: CNT_W].
- active  out  2  index of the direction owning the current phase.
- tick  out  1  one-cycle pulse per elapsed second.

## Operation
- Prescaler pc counts 0..CLK_PER_SEC-1. `tick` is 1 when pc==CLK_PER_SEC-1, then pc wraps to 0.
- States are GREEN, YELLOW, ALL_RED and NIGHT. Register `sec` holds the seconds remaining in the current state and decrements on tick.
- On a tick with sec==1:
  - GREEN → YELLOW, with sec=YELLOW_TIME.
  - YELLOW → ALL_RED, with sec=YELLOW_TIME replaced by sec=ALL_RED_TIME.
  - ALL_RED → GREEN, with active=(active+1) mod NUM_DIR and sec=GREEN_TIME. If night_mode=1 at this tick, go to NIGHT instead.
- Lamps are decoded directly from the state registers:
  - GREEN: green[active]=1; all other directions red.
  - YELLOW: yellow[active]=1; all other directions red.
  - ALL_RED: all red.
  - NIGHT: red=green=0; every yellow equals the blink bit, which starts at 1 on entry and toggles on every tick.
- Pedestrian handling:
  - ped_req[i] sets latch p[i].
  - p[i] clears on the cycle direction i enters GREEN.
  - Requests for the active direction while it is green are ignored.
  - While in GREEN, if any p[j] with j≠active is set and sec>MIN_GREEN, then sec is loaded with MIN_GREEN on the next cycle. A load is not a decrement.
  - If that cycle is also a tick, the load wins.
- Night exit: in NIGHT, night_mode=0 sampled on a tick → ALL_RED with sec=ALL_RED_TIME and active=NUM_DIR-1, so direction 0 is green next. p latches are kept.
- Countdown, with PHASE=GREEN_TIME+YELLOW_TIME+ALL_RED_TIME:
  - Active direction in GREEN or YELLOW: count=sec.
  - Any other direction i: let d=(i-active) mod NUM_DIR, with d=NUM_DIR when i==active (ALL_RED). rem = seconds until the end of the current ALL_RED: sec+YELLOW_TIME+ALL_RED_TIME in GREEN, sec+ALL_RED_TIME in YELLOW, sec in ALL_RED. Then count_i=rem+(d-1)*PHASE.
  - NIGHT: all counts 0.
  - Saturate at 2^CNT_W-1.
  - The sum is computed at CNT_W+4 bits before saturation.

## Timing
- Reset values: state=ALL_RED, sec=ALL_RED_TIME, active=NUM_DIR-1, pc=0, p=0, blink=0, tick=0. Lamps are all red, yellow=green=0. count_i=ALL_RED_TIME+(i)*PHASE for i<NUM_DIR-1, with d computed as above; direction NUM_DIR-1 gets ALL_RED_TIME+(NUM_DIR-1)*PHASE.
- Reset mid-phase returns to the reset state in one cycle and clears the latches.
- State, lamps and active change on the clock edge that follows the tick cycle. count is combinational from registers, with zero added latency.
- First tick is CLK_PER_SEC cycles after rst deasserts.
- ped_req is latched 1 cycle after it is asserted. A pulse arriving on the same cycle that p[i] clears re-sets the latch.
- night_mode is only sampled at ALL_RED→GREEN ticks and, while in NIGHT, on ticks. Level changes between samples have no effect.

## Test plan
- Parameters NUM_DIR=3, CLK_PER_SEC=4, G=5, Y=2, AR=1, MIN_GREEN=2, so PHASE=8.
- Reset → red=3'b111, counts {dir0,1,2}={1,9,17}. After 4 cycles, tick; next edge green[0]=1, count0=5, count1=8, count2=16.
- Free run for 24 s → green rotates 0→1→2→0. Each green lasts 20 cycles, yellow 8, all-red 4. The active count runs 5..1 then 2..1.
- ped_req[2] pulse at dir0 green with sec=4 → sec=2 next cycle and green ends 2 ticks later. p[2] clears when dir2 turns green. A request at sec=2 causes no change.
- night_mode=1 during dir0 green → full sequence to the end of ALL_RED, then NIGHT with yellow=3'b111. Toggle every 4 cycles, red=green=0, counts 0. Drop night_mode → ALL_RED for 1 s, then green[0].
- rst asserted mid-YELLOW → next cycle matches the reset values exactly, and pc restarts from 0.
